fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_counter.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-fed UART transmitter:
//   - uart_state_e         : transmit FSM state encoding
//   - DEFAULT_DATA_WIDTH   : default frame payload width (bits)
//   - DEFAULT_CLKS_PER_BIT : default clk cycles per UART bit
//   - FRAME_COUNT_WIDTH    : width of the completed-frame counter
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 32'd8;
   localparam int DEFAULT_CLKS_PER_BIT = 32'd16;
   localparam int FRAME_COUNT_WIDTH    = 32'd16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_POP       = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_START     = 3'd3,
      ST_DATA      = 3'd4,
      ST_STOP      = 3'd5
   } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and raises tick for the one
// cycle in which the count sits at CLKS_PER_BIT-1, then wraps to 0.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (count -> 0)
//   clear : synchronous restart of the bit period (count -> 0)
//   tick  : high during the last cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 32'd1);

   logic [CNT_W-1:0] count_r;

   // Bit-period count register with reset, restart and wrap at CNT_MAX
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (count_r == CNT_MAX) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + CNT_W'(1'b1);
      end
   end

   assign tick = (count_r == CNT_MAX);

endmodule : uart_baud_counter

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pulls words from an upstream FIFO and sends each as an 8N1-style UART frame
// (start bit, DATA_WIDTH data bits LSB first, one stop bit).
// Ports:
//   clk             : rising-edge clock
//   reset           : synchronous active-high reset
//   enable          : allows a new frame to start (never aborts one in flight)
//   fifo_empty      : upstream FIFO empty flag
//   fifo_pop        : one-cycle pop strobe to the FIFO (registered)
//   fifo_data       : FIFO read data
//   fifo_data_valid : qualifies fifo_data; only looked at in WAIT_DATA
//   tx              : serial line, idles high (registered)
//   busy            : high whenever the FSM is not in IDLE (registered)
//   frame_count     : number of completed frames, wraps (registered)
// -----------------------------------------------------------------------------
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         fifo_empty,
   output logic                         fifo_pop,
   input  logic [DATA_WIDTH-1:0]        fifo_data,
   input  logic                         fifo_data_valid,
   output logic                         tx,
   output logic                         busy,
   output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

   localparam int IDX_W = (DATA_WIDTH > 32'd1) ? $clog2(DATA_WIDTH) : 32'd1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 32'd1);

   uart_state_e                  state_r;
   uart_state_e                  state_s;
   logic [DATA_WIDTH-1:0]        shift_r;
   logic [DATA_WIDTH-1:0]        shift_s;
   logic [IDX_W-1:0]             bit_idx_r;
   logic [IDX_W-1:0]             bit_idx_s;
   logic [FRAME_COUNT_WIDTH-1:0] frame_count_r;
   logic [FRAME_COUNT_WIDTH-1:0] frame_count_s;
   logic                         tx_r;
   logic                         tx_s;
   logic                         fifo_pop_r;
   logic                         fifo_pop_s;
   logic                         busy_r;
   logic                         busy_s;
   logic                         tick_s;
   logic                         clear_s;

   // Restart the bit period on every state change so each bit gets a full period
   assign clear_s = (state_s != state_r);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (clear_s),
      .tick  (tick_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (enable && !fifo_empty) begin
               state_s = ST_POP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_POP: begin
            state_s = ST_WAIT_DATA;
         end
         ST_WAIT_DATA: begin
            if (fifo_data_valid) begin
               state_s = ST_START;
            end else begin
               state_s = ST_WAIT_DATA;
            end
         end
         ST_START: begin
            if (tick_s) begin
               state_s = ST_DATA;
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s && (bit_idx_r == LAST_IDX)) begin
               state_s = ST_STOP;
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (tick_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_STOP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Datapath next values: shift register, bit index and frame counter
   always_comb begin
      shift_s       = shift_r;
      bit_idx_s     = bit_idx_r;
      frame_count_s = frame_count_r;
      case (state_r)
         ST_WAIT_DATA: begin
            if (fifo_data_valid) begin
               shift_s = fifo_data;
            end else begin
               shift_s = shift_r;
            end
         end
         ST_START: begin
            bit_idx_s = '0;
         end
         ST_DATA: begin
            if (tick_s) begin
               shift_s   = shift_r >> 1'b1;
               bit_idx_s = bit_idx_r + IDX_W'(1'b1);
            end else begin
               shift_s   = shift_r;
               bit_idx_s = bit_idx_r;
            end
         end
         ST_STOP: begin
            if (tick_s) begin
               frame_count_s = frame_count_r + 16'd1;
            end else begin
               frame_count_s = frame_count_r;
            end
         end
         default: begin
            shift_s = shift_r;
         end
      endcase
   end

   // Output decode from the upcoming state so tx/pop/busy can be registered
   // without a cycle of lag; in DATA the line carries the LSB of the next shift value
   always_comb begin
      fifo_pop_s = (state_s == ST_POP);
      busy_s     = (state_s != ST_IDLE);
      case (state_s)
         ST_START: tx_s = 1'b0;
         ST_DATA:  tx_s = shift_s[0];
         default:  tx_s = 1'b1;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_r       <= '0;
         bit_idx_r     <= '0;
         frame_count_r <= '0;
         tx_r          <= 1'b1;
         fifo_pop_r    <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         shift_r       <= shift_s;
         bit_idx_r     <= bit_idx_s;
         frame_count_r <= frame_count_s;
         tx_r          <= tx_s;
         fifo_pop_r    <= fifo_pop_s;
         busy_r        <= busy_s;
      end
   end

   assign tx          = tx_r;
   assign fifo_pop    = fifo_pop_r;
   assign busy        = busy_r;
   assign frame_count = frame_count_r;

endmodule : fifo_uart_tx

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4) with a
// one-cycle-latency FIFO model. Inputs change and outputs are sampled on the
// falling edge of clk.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

   localparam int DW  = 32'd8;
   localparam int CPB = 32'd4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [DW-1:0] fifo_data;
   logic          fifo_data_valid;
   logic          tx;
   logic          busy;
   logic [15:0]   frame_count;

   int n_checks = 0;
   int n_errors = 0;

   // FIFO model: initial block owns wr_ptr/mem, the clocked model owns rd_ptr
   logic [DW-1:0] mem [0:15];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   int            pop_cnt = 0;
   logic          model_valid = 1'b0;
   logic [DW-1:0] model_data = 8'h00;
   logic          spur_valid = 1'b0;
   logic [DW-1:0] spur_data = 8'h00;

   int   lat;
   logic saw_pop;
   logic saw_busy;
   logic saw_low;

   fifo_uart_tx #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .fifo_empty      (fifo_empty),
      .fifo_pop        (fifo_pop),
      .fifo_data       (fifo_data),
      .fifo_data_valid (fifo_data_valid),
      .tx              (tx),
      .busy            (busy),
      .frame_count     (frame_count)
   );

   always #5 clk = ~clk;

   assign fifo_empty      = (wr_ptr == rd_ptr);
   assign fifo_data_valid = model_valid | spur_valid;
   assign fifo_data       = model_valid ? model_data : spur_data;

   always @(posedge clk) begin
      if ((fifo_pop === 1'b1) && (rd_ptr != wr_ptr)) begin
         model_data  <= mem[rd_ptr];
         model_valid <= 1'b1;
         rd_ptr      <= rd_ptr + 1;
      end else begin
         model_valid <= 1'b0;
      end
      if (fifo_pop === 1'b1) pop_cnt <= pop_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] d);
      mem[wr_ptr] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   // Returns the number of falling edges until tx is seen low, -1 on timeout
   task automatic wait_tx_low(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            cycles = i;
            break;
         end
      end
   endtask

   // Call at the falling edge of the first START cycle; checks all 40 cycles
   task automatic frame_check(input string tag, input logic [DW-1:0] d, input logic spur);
      logic [9:0] bits;
      bits = {1'b1, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < CPB; c++) begin
            if ((b != 0) || (c != 0)) @(negedge clk);
            if (spur && (b == 9) && (c == 1)) begin
               spur_data  = ~d;
               spur_valid = 1'b1;
            end else begin
               spur_valid = 1'b0;
            end
            check($sformatf("%s_bit%0d_c%0d", tag, b, c), 32'(tx), 32'(bits[b]));
         end
      end
      spur_valid = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pop", 32'(fifo_pop), 32'd0);
      check("rst_count", 32'(frame_count), 32'd0);
      reset  = 1'b0;
      enable = 1'b1;

      // Empty FIFO: nothing may happen
      saw_pop = 1'b0; saw_busy = 1'b0; saw_low = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (fifo_pop !== 1'b0) saw_pop = 1'b1;
         if (busy !== 1'b0) saw_busy = 1'b1;
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      check("empty_pop", 32'(saw_pop), 32'd0);
      check("empty_busy", 32'(saw_busy), 32'd0);
      check("empty_txlow", 32'(saw_low), 32'd0);
      check("empty_popcnt", 32'(pop_cnt), 32'd0);

      // Single frame 0xA5
      push(8'hA5);
      wait_tx_low(lat);
      check("a5_latency", 32'(lat), 32'd3);
      frame_check("a5", 8'hA5, 1'b0);
      @(negedge clk);
      check("a5_count", 32'(frame_count), 32'd1);
      check("a5_pops", 32'(pop_cnt), 32'd1);
      check("a5_busy", 32'(busy), 32'd0);

      // Back-to-back 0x00 then 0xFF with a 3-cycle high gap
      push(8'h00);
      push(8'hFF);
      wait_tx_low(lat);
      check("b2b_latency", 32'(lat), 32'd3);
      frame_check("x00", 8'h00, 1'b0);
      for (int g = 0; g < 3; g++) begin
         @(negedge clk);
         check($sformatf("gap%0d_tx", g), 32'(tx), 32'd1);
         check($sformatf("gap%0d_pop", g), 32'(fifo_pop), (g == 1) ? 32'd1 : 32'd0);
         if (g == 0) check("gap_count", 32'(frame_count), 32'd2);
      end
      @(negedge clk);
      frame_check("xff", 8'hFF, 1'b0);
      @(negedge clk);
      check("b2b_count", 32'(frame_count), 32'd3);
      check("b2b_pops", 32'(pop_cnt), 32'd3);

      // Enable dropped mid-frame: frame completes, next pop waits for enable
      push(8'h3C);
      push(8'h81);
      wait_tx_low(lat);
      check("en_latency", 32'(lat), 32'd3);
      enable = 1'b0;
      frame_check("x3c", 8'h3C, 1'b0);
      saw_pop = 1'b0; saw_busy = 1'b0; saw_low = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (fifo_pop !== 1'b0) saw_pop = 1'b1;
         if (busy !== 1'b0) saw_busy = 1'b1;
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      check("en_off_pop", 32'(saw_pop), 32'd0);
      check("en_off_busy", 32'(saw_busy), 32'd0);
      check("en_off_txlow", 32'(saw_low), 32'd0);
      check("en_off_count", 32'(frame_count), 32'd4);
      check("en_off_pops", 32'(pop_cnt), 32'd4);
      enable = 1'b1;
      wait_tx_low(lat);
      check("en_on_latency", 32'(lat), 32'd3);
      frame_check("x81", 8'h81, 1'b0);
      @(negedge clk);
      check("en_on_count", 32'(frame_count), 32'd5);

      // Reset during data bit 3 (0x52 has bit 3 = 0, so the line is low)
      push(8'h52);
      wait_tx_low(lat);
      check("rst_mid_latency", 32'(lat), 32'd3);
      repeat (17) @(negedge clk);
      check("rst_mid_pre_tx", 32'(tx), 32'd0);
      check("rst_mid_pre_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_tx", 32'(tx), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_count", 32'(frame_count), 32'd0);
      check("rst_mid_pop", 32'(fifo_pop), 32'd0);
      reset = 1'b0;
      push(8'hC3);
      wait_tx_low(lat);
      check("post_rst_latency", 32'(lat), 32'd3);
      frame_check("xc3", 8'hC3, 1'b0);
      @(negedge clk);
      check("post_rst_count", 32'(frame_count), 32'd1);
      check("post_rst_pops", 32'(pop_cnt), 32'd7);

      // Counter wrap plus a spurious valid during STOP
      force dut.frame_count_r = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count_r;
      @(negedge clk);
      check("wrap_preload", 32'(frame_count), 32'h0000FFFF);
      push(8'h96);
      wait_tx_low(lat);
      check("wrap_latency", 32'(lat), 32'd3);
      frame_check("x96", 8'h96, 1'b1);
      @(negedge clk);
      check("wrap_count", 32'(frame_count), 32'd0);
      saw_busy = 1'b0; saw_low = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (busy !== 1'b0) saw_busy = 1'b1;
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      check("spur_busy", 32'(saw_busy), 32'd0);
      check("spur_txlow", 32'(saw_low), 32'd0);
      check("spur_pops", 32'(pop_cnt), 32'd8);
      check("spur_count", 32'(frame_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_fifo_uart_tx
